// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/flush controller.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package pipe_hazard_ctrl_pkg;

  // Controller FSM encodings (2 bits).
  typedef enum logic [1:0] {
    CTRL_RUN   = 2'd0,
    CTRL_STALL = 2'd1,
    CTRL_FLUSH = 2'd2,
    CTRL_HOLD  = 2'd3
  } ctrl_state_t;

  localparam logic HoldEnable   = 1'b1;
  localparam logic HoldDisable  = 1'b0;
  localparam logic JumpEnable   = 1'b1;
  localparam logic JumpDisable  = 1'b0;

  localparam logic [4:0]  ZeroReg  = 5'd0;
  localparam logic [31:0] ZeroWord = 32'd0;
  localparam logic [31:0] INST_NOP = 32'h0000_0013;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_scoreboard.sv
// In-flight register-write scoreboard: WB_LAT-deep shift register of {valid, rd}
// with RAW match comparators against the two ID source addresses.
// Latency: hazard is combinational from slot state and rs1/rs2; slots update on clk.
// Backpressure: shift_en=0 freezes all slots; advance=0 pushes a bubble into slot 0.
// Ports: clk, rst_n (sync, active-low), shift_en, push_valid, push_rd, advance,
//        rs1, rs2 -> hazard.
module hazard_scoreboard import pipe_hazard_ctrl_pkg::*; #(
  parameter int WB_LAT = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       shift_en,
  input  logic       push_valid,
  input  logic [4:0] push_rd,
  input  logic       advance,
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  output logic       hazard
);

  logic [WB_LAT-1:0]      slot_vld;
  logic [WB_LAT-1:0][4:0] slot_rd;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_vld <= '0;
      slot_rd  <= '0;
    end else if (shift_en) begin
      // Slot k holds the instruction k+1 stages past ID; the top slot retires.
      for (int k = WB_LAT - 1; k > 0; k--) begin
        slot_vld[k] <= slot_vld[k-1];
        slot_rd[k]  <= slot_rd[k-1];
      end
      slot_vld[0] <= advance && push_valid;
      slot_rd[0]  <= push_rd;
    end
  end

  always_comb begin
    hazard = 1'b0;
    for (int k = 0; k < WB_LAT; k++) begin
      if (slot_vld[k] &&
          (((rs1 != ZeroReg) && (slot_rd[k] == rs1)) ||
           ((rs2 != ZeroReg) && (slot_rd[k] == rs2)))) begin
        hazard = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline controller: RAW stall via scoreboard, jump redirect + flush sequencing,
// external front-end freeze with pending-jump capture.
// Latency: all outputs combinational from registered state and current inputs.
// Backpressure: ext_hold_i freezes PC/if_id/id_ex and the scoreboard; jumps seen
//   during a hold are replayed on the first released cycle.
// Optional: PIPE_CTRL_PERF_EN adds stall_cnt_o/flush_cnt_o/hold_cnt_o cycle counters.
// Ports: clk, rst_n (sync, active-low); ID rs1/rs2/rd/reg_wen; EX jump en/addr;
//   ext_hold_i; outputs jump_en/addr, hold_pc/if_id/id_ex, flush_if_id/id_ex.
module pipe_hazard_ctrl import pipe_hazard_ctrl_pkg::*; #(
  parameter int WB_LAT    = 3,
  parameter int FLUSH_CYC = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  id_rs1_addr_i,
  input  logic [4:0]  id_rs2_addr_i,
  input  logic [4:0]  id_rd_addr_i,
  input  logic        id_reg_wen_i,
  input  logic        ex_jump_en_i,
  input  logic [31:0] ex_jump_addr_i,
  input  logic        ext_hold_i,
  output logic        jump_en_o,
  output logic [31:0] jump_addr_o,
  output logic        hold_pc_o,
  output logic        hold_if_id_o,
  output logic        hold_id_ex_o,
  output logic        flush_if_id_o,
`ifdef PIPE_CTRL_PERF_EN
  output logic        flush_id_ex_o,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o,
  output logic [31:0] hold_cnt_o
`else
  output logic        flush_id_ex_o
`endif
);

  ctrl_state_t state_q, state_d;
  logic [1:0]  fcnt_q, fcnt_d;
  logic        pend_vld_q, pend_vld_d;
  logic [31:0] pend_addr_q, pend_addr_d;
  logic        hazard;
  logic        stall_now;
  logic        jflush_now;

  hazard_scoreboard #(.WB_LAT(WB_LAT)) u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .shift_en   (!ext_hold_i),
    .push_valid (id_reg_wen_i && (id_rd_addr_i != ZeroReg)),
    .push_rd    (id_rd_addr_i),
    // ID only advances when nothing is bubbling id_ex (stall or flush).
    .advance    (!flush_id_ex_o),
    .rs1        (id_rs1_addr_i),
    .rs2        (id_rs2_addr_i),
    .hazard     (hazard)
  );

  always_comb begin
    state_d       = state_q;
    fcnt_d        = fcnt_q;
    pend_vld_d    = pend_vld_q;
    pend_addr_d   = pend_addr_q;
    jump_en_o     = JumpDisable;
    jump_addr_o   = ZeroWord;
    hold_pc_o     = HoldDisable;
    hold_if_id_o  = HoldDisable;
    hold_id_ex_o  = HoldDisable;
    flush_if_id_o = 1'b0;
    flush_id_ex_o = 1'b0;
    stall_now     = 1'b0;
    jflush_now    = 1'b0;

    if (!rst_n) begin
      flush_if_id_o = 1'b1;
      flush_id_ex_o = 1'b1;
    end else if (ext_hold_i) begin
      hold_pc_o    = HoldEnable;
      hold_if_id_o = HoldEnable;
      hold_id_ex_o = HoldEnable;
      state_d      = CTRL_HOLD;
      // Latest jump wins; it is replayed when the hold releases.
      if (ex_jump_en_i) begin
        pend_vld_d  = 1'b1;
        pend_addr_d = ex_jump_addr_i;
      end
    end else if (ex_jump_en_i || pend_vld_q) begin
      jump_en_o     = JumpEnable;
      jump_addr_o   = ex_jump_en_i ? ex_jump_addr_i : pend_addr_q;
      flush_if_id_o = 1'b1;
      flush_id_ex_o = 1'b1;
      jflush_now    = 1'b1;
      pend_vld_d    = 1'b0;
      if (FLUSH_CYC > 1) begin
        state_d = CTRL_FLUSH;
        // Counter holds the FLUSH cycles remaining after the next one.
        fcnt_d  = 2'(FLUSH_CYC - 2);
      end else begin
        state_d = CTRL_RUN;
      end
    end else if (state_q == CTRL_FLUSH) begin
      flush_if_id_o = 1'b1;
      flush_id_ex_o = 1'b1;
      jflush_now    = 1'b1;
      if (fcnt_q == 2'd0) begin
        state_d = CTRL_RUN;
      end else begin
        fcnt_d = fcnt_q - 2'd1;
      end
    end else if (hazard) begin
      hold_pc_o     = HoldEnable;
      hold_if_id_o  = HoldEnable;
      flush_id_ex_o = 1'b1;
      stall_now     = 1'b1;
      state_d       = CTRL_STALL;
    end else begin
      state_d = CTRL_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= CTRL_RUN;
      fcnt_q      <= 2'd0;
      pend_vld_q  <= 1'b0;
      pend_addr_q <= ZeroWord;
    end else begin
      state_q     <= state_d;
      fcnt_q      <= fcnt_d;
      pend_vld_q  <= pend_vld_d;
      pend_addr_q <= pend_addr_d;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  // Free-running event counters; they keep counting while the pipe is held.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_o <= 32'd0;
      flush_cnt_o <= 32'd0;
      hold_cnt_o  <= 32'd0;
    end else begin
      if (stall_now)  stall_cnt_o <= stall_cnt_o + 32'd1;
      if (jflush_now) flush_cnt_o <= flush_cnt_o + 32'd1;
      if (ext_hold_i) hold_cnt_o  <= hold_cnt_o + 32'd1;
    end
  end
`else
  // Only consumed by the optional counters.
  logic unused_perf;
  assign unused_perf = stall_now ^ jflush_now;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl (WB_LAT=3, FLUSH_CYC=2).
// Latency: table vectors applied one per cycle, checked at the falling edge.
// Backpressure: n/a.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i;
  logic        id_reg_wen_i, ex_jump_en_i, ext_hold_i;
  logic [31:0] ex_jump_addr_i;
  logic        jump_en_o, hold_pc_o, hold_if_id_o, hold_id_ex_o;
  logic        flush_if_id_o, flush_id_ex_o;
  logic [31:0] jump_addr_o;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt_o, flush_cnt_o, hold_cnt_o;
  int unsigned m_stall = 0, m_flush = 0, m_hold = 0;
`endif

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.WB_LAT(3), .FLUSH_CYC(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .id_rs1_addr_i  (id_rs1_addr_i),
    .id_rs2_addr_i  (id_rs2_addr_i),
    .id_rd_addr_i   (id_rd_addr_i),
    .id_reg_wen_i   (id_reg_wen_i),
    .ex_jump_en_i   (ex_jump_en_i),
    .ex_jump_addr_i (ex_jump_addr_i),
    .ext_hold_i     (ext_hold_i),
    .jump_en_o      (jump_en_o),
    .jump_addr_o    (jump_addr_o),
    .hold_pc_o      (hold_pc_o),
    .hold_if_id_o   (hold_if_id_o),
    .hold_id_ex_o   (hold_id_ex_o),
    .flush_if_id_o  (flush_if_id_o),
`ifdef PIPE_CTRL_PERF_EN
    .flush_id_ex_o  (flush_id_ex_o),
    .stall_cnt_o    (stall_cnt_o),
    .flush_cnt_o    (flush_cnt_o),
    .hold_cnt_o     (hold_cnt_o)
`else
    .flush_id_ex_o  (flush_id_ex_o)
`endif
  );

  // Flag order: {hold_pc, hold_if_id, hold_id_ex, flush_if_id, flush_id_ex}
  localparam logic [4:0] N   = 5'b00000;
  localparam logic [4:0] STL = 5'b11001;
  localparam logic [4:0] FL  = 5'b00011;
  localparam logic [4:0] HLD = 5'b11100;
  localparam logic [4:0] RST = 5'b00011;

  typedef struct {
    logic        rst_n;
    logic [4:0]  rs1, rs2, rd;
    logic        wen, jmp;
    logic [31:0] jaddr;
    logic        hold;
    logic        jen;
    logic [31:0] eaddr;
    logic [4:0]  flags;
    string       name;
  } vec_t;

  vec_t        tbl[$];
  logic [37:0] exp_q[$];
  string       name_q[$];
  int          errors = 0;
  int          checks = 0;

  function automatic vec_t mk(input logic r, input logic [4:0] s1, input logic [4:0] s2,
                              input logic [4:0] d, input logic w, input logic j,
                              input logic [31:0] ja, input logic h, input logic je,
                              input logic [31:0] ea, input logic [4:0] f, input string n);
    vec_t v;
    v.rst_n = r; v.rs1 = s1; v.rs2 = s2; v.rd = d; v.wen = w; v.jmp = j;
    v.jaddr = ja; v.hold = h; v.jen = je; v.eaddr = ea; v.flags = f; v.name = n;
    return v;
  endfunction

  // Drive one cycle of stimulus, queue its expectation, then check at negedge.
  task automatic apply(input vec_t v);
    logic [37:0] got, exp;
    string nm;
    @(posedge clk);
    #1;
    rst_n = v.rst_n; id_rs1_addr_i = v.rs1; id_rs2_addr_i = v.rs2;
    id_rd_addr_i = v.rd; id_reg_wen_i = v.wen; ex_jump_en_i = v.jmp;
    ex_jump_addr_i = v.jaddr; ext_hold_i = v.hold;
    exp_q.push_back({v.jen, v.eaddr, v.flags});
    name_q.push_back(v.name);
`ifdef PIPE_CTRL_PERF_EN
    if (!v.rst_n) begin
      m_stall = 0; m_flush = 0; m_hold = 0;
    end else begin
      if (v.flags == STL) m_stall++;
      if (v.flags == FL)  m_flush++;
      if (v.flags == HLD) m_hold++;
    end
`endif
    @(negedge clk);
    got = {jump_en_o, jump_addr_o, hold_pc_o, hold_if_id_o, hold_id_ex_o,
           flush_if_id_o, flush_id_ex_o};
    exp = exp_q.pop_front();
    nm  = name_q.pop_front();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got jen=%0b addr=%h flags=%b, expected jen=%0b addr=%h flags=%b",
               nm, got[37], got[36:5], got[4:0], exp[37], exp[36:5], exp[4:0]);
    end
  endtask

  initial begin
    rst_n = 1'b0; id_rs1_addr_i = '0; id_rs2_addr_i = '0; id_rd_addr_i = '0;
    id_reg_wen_i = 1'b0; ex_jump_en_i = 1'b0; ex_jump_addr_i = '0; ext_hold_i = 1'b0;

    //               rst rs1 rs2 rd wen jmp jaddr        hold jen eaddr        flags
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,   0, 0, 32'h0,   RST, "reset0"));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 32'h44,  1, 0, 32'h0,   RST, "reset1"));
    // addi x1 ; add x2,x1,x1 -> 3 stall cycles
    tbl.push_back(mk(1, 0, 0, 1, 1, 0, 32'h0,   0, 0, 32'h0,   N,   "raw_addi"));
    tbl.push_back(mk(1, 1, 1, 2, 1, 0, 32'h0,   0, 0, 32'h0,   STL, "raw_stall1"));
    tbl.push_back(mk(1, 1, 1, 2, 1, 0, 32'h0,   0, 0, 32'h0,   STL, "raw_stall2"));
    tbl.push_back(mk(1, 1, 1, 2, 1, 0, 32'h0,   0, 0, 32'h0,   STL, "raw_stall3"));
    tbl.push_back(mk(1, 1, 1, 2, 1, 0, 32'h0,   0, 0, 32'h0,   N,   "raw_release"));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 32'h0,   0, 0, 32'h0,   N,   "nop_a"));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 32'h0,   0, 0, 32'h0,   N,   "nop_b"));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 32'h0,   0, 0, 32'h0,   N,   "nop_c"));
    // write x0 then read x0
    tbl.push_back(mk(1, 0, 0, 0, 1, 0, 32'h0,   0, 0, 32'h0,   N,   "x0_write"));
    tbl.push_back(mk(1, 0, 5, 0, 0, 0, 32'h0,   0, 0, 32'h0,   N,   "x0_read"));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 32'h0,   0, 0, 32'h0,   N,   "x0_after"));
    // jump coinciding with a hazard, FLUSH_CYC=2
    tbl.push_back(mk(1, 0, 0, 3, 1, 0, 32'h0,   0, 0, 32'h0,   N,   "jh_write"));
    tbl.push_back(mk(1, 3, 0, 0, 0, 1, 32'h100, 0, 1, 32'h100, FL,  "jh_jump"));
    tbl.push_back(mk(1, 3, 0, 0, 0, 0, 32'h0,   0, 0, 32'h0,   FL,  "jh_flush2"));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 32'h0,   0, 0, 32'h0,   N,   "jh_run"));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 32'h0,   0, 0, 32'h0,   N,   "jh_run2"));
    // hold 4 cycles, jump arrives on cycle 2
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 32'h0,   1, 0, 32'h0,   HLD, "hold1"));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 32'h200, 1, 0, 32'h0,   HLD, "hold2_jump"));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 32'h0,   1, 0, 32'h0,   HLD, "hold3"));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 32'h0,   1, 0, 32'h0,   HLD, "hold4"));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 32'h0,   0, 1, 32'h200, FL,  "hold_replay"));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 32'h0,   0, 0, 32'h0,   FL,  "hold_flush2"));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 32'h0,   0, 0, 32'h0,   N,   "hold_run"));
    // jump at hold entry, overwritten by a later one
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 32'h300, 1, 0, 32'h0,   HLD, "ovw_entry"));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 32'h400, 1, 0, 32'h0,   HLD, "ovw_second"));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 32'h0,   0, 1, 32'h400, FL,  "ovw_replay"));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 32'h0,   0, 0, 32'h0,   FL,  "ovw_flush2"));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 32'h0,   0, 0, 32'h0,   N,   "ovw_cleared"));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 32'h0,   0, 0, 32'h0,   N,   "ovw_idle"));
    // hold freezes the scoreboard; hazard resumes on release
    tbl.push_back(mk(1, 0, 0, 4, 1, 0, 32'h0,   0, 0, 32'h0,   N,   "hz_write"));
    tbl.push_back(mk(1, 4, 0, 0, 0, 0, 32'h0,   1, 0, 32'h0,   HLD, "hz_hold1"));
    tbl.push_back(mk(1, 4, 0, 0, 0, 0, 32'h0,   1, 0, 32'h0,   HLD, "hz_hold2"));
    tbl.push_back(mk(1, 4, 0, 0, 0, 0, 32'h0,   0, 0, 32'h0,   STL, "hz_stall1"));
    tbl.push_back(mk(1, 4, 0, 0, 0, 0, 32'h0,   0, 0, 32'h0,   STL, "hz_stall2"));
    tbl.push_back(mk(1, 4, 0, 0, 0, 0, 32'h0,   0, 0, 32'h0,   STL, "hz_stall3"));
    tbl.push_back(mk(1, 4, 0, 0, 0, 0, 32'h0,   0, 0, 32'h0,   N,   "hz_release"));
    // reset mid-stall and mid-hold with a pending jump
    tbl.push_back(mk(1, 0, 0, 5, 1, 0, 32'h0,   0, 0, 32'h0,   N,   "rs_write"));
    tbl.push_back(mk(1, 0, 5, 0, 0, 0, 32'h0,   0, 0, 32'h0,   STL, "rs_stall"));
    tbl.push_back(mk(0, 0, 5, 0, 0, 0, 32'h0,   0, 0, 32'h0,   RST, "rs_reset"));
    tbl.push_back(mk(1, 0, 5, 0, 0, 0, 32'h0,   0, 0, 32'h0,   N,   "rs_nostall"));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 32'h500, 1, 0, 32'h0,   HLD, "rs_pend"));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,   0, 0, 32'h0,   RST, "rs_reset2"));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 32'h0,   0, 0, 32'h0,   N,   "rs_no_replay"));
    // new jump during FLUSH restarts the counter
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 32'h600, 0, 1, 32'h600, FL,  "fr_jump1"));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 32'h700, 0, 1, 32'h700, FL,  "fr_jump2"));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 32'h0,   0, 0, 32'h0,   FL,  "fr_flush2"));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 32'h0,   0, 0, 32'h0,   N,   "fr_run"));

    foreach (tbl[i]) apply(tbl[i]);

    // x0 writers followed by random readers: never a stall.
    for (int i = 0; i < 16; i++) begin
      logic [4:0] r1, r2;
      r1 = 5'($urandom_range(0, 31));
      r2 = 5'($urandom_range(0, 31));
      apply(mk(1, r1, r2, 0, 1, 0, 32'h0, 0, 0, 32'h0, N, "x0_random"));
    end

`ifdef PIPE_CTRL_PERF_EN
    @(posedge clk);
    #1;
    checks++;
    if (stall_cnt_o !== m_stall) begin
      errors++; $display("FAIL stall_cnt: got %0d expected %0d", stall_cnt_o, m_stall);
    end
    checks++;
    if (flush_cnt_o !== m_flush) begin
      errors++; $display("FAIL flush_cnt: got %0d expected %0d", flush_cnt_o, m_flush);
    end
    checks++;
    if (hold_cnt_o !== m_hold) begin
      errors++; $display("FAIL hold_cnt: got %0d expected %0d", hold_cnt_o, m_hold);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
